// File: rtl/mult_mac_sequencer.sv
// Purpose: runs one multiply-accumulate (dot-product) job on a shared pipelined multiplier.
// Latency: done pulses len+MEM_LAT+PIPE+1 cycles after an accepted start (1 cycle when len==0).
// Backpressure: none; one operand read is issued per cycle, and start is ignored unless idle.
//
// Ports:
//   clock, aclr_n            - clock (rising edge) and asynchronous active-low reset
//   start, abort             - job request (taken only in IDLE) and job cancel
//   base_addr, len           - first operand address and pair count, captured on accepted start
//   rd_en, rd_addr           - operand buffer read strobe and address
//   rd_data_a, rd_data_b     - operands returned MEM_LAT cycles after rd_en
//   mult_dataa/datab/clken   - multiplier operand pass-through and clock enable
//   mult_result              - product, PIPE cycles after the operands
//   busy, done               - job in progress, one-cycle completion pulse
//   acc_out, overflow        - final sum and sticky overflow, held until the next job completes
module mult_mac_sequencer #(
    parameter int    WIDTH_A        = 8,
    parameter int    WIDTH_B        = 8,
    parameter int    WIDTH_P        = 16,
    parameter int    ACC_W          = 24,
    parameter int    ADDR_W         = 10,
    parameter int    LEN_W          = 10,
    parameter int    MEM_LAT        = 1,
    parameter int    PIPE           = 2,
    parameter string REPRESENTATION = "SIGNED"
) (
    input  logic               clock,
    input  logic               aclr_n,
    input  logic               start,
    input  logic               abort,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   len,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [WIDTH_A-1:0] rd_data_a,
    input  logic [WIDTH_B-1:0] rd_data_b,
    output logic [WIDTH_A-1:0] mult_dataa,
    output logic [WIDTH_B-1:0] mult_datab,
    output logic               mult_clken,
    input  logic [WIDTH_P-1:0] mult_result,
    output logic               busy,
    output logic               done,
    output logic [ACC_W-1:0]   acc_out,
    output logic               overflow
);

    // Total cycles from a read strobe to its product appearing on mult_result.
    localparam int DEPTH     = MEM_LAT + PIPE;
    localparam bit IS_SIGNED = (REPRESENTATION == "SIGNED");

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               accept;
    logic               last_read;
    logic               tail_empty;
    logic [LEN_W-1:0]   remaining;
    logic [DEPTH-1:0]   vld_pipe;
    logic               product_vld;
    logic [ACC_W-1:0]   acc;
    logic               acc_ovf;
    logic [ACC_W-1:0]   product_ext;
    logic [ACC_W:0]     sum_wide;
    logic [ACC_W-1:0]   acc_sum;
    logic               add_ovf;
    logic [ACC_W-1:0]   acc_nxt;
    logic               ovf_nxt;

    assign rd_en       = (state == S_ISSUE);
    assign busy        = (state == S_ISSUE) || (state == S_DRAIN);
    assign done        = (state == S_DONE);
    assign mult_clken  = (state != S_IDLE);
    assign mult_dataa  = rd_data_a;
    assign mult_datab  = rd_data_b;

    assign last_read   = (remaining == LEN_W'(1));
    assign product_vld = vld_pipe[DEPTH-1];

    // In DRAIN no new reads enter, so the pipe is empty after this edge
    // exactly when everything below the output tap is already clear.
    generate
        if (DEPTH == 1) begin : g_tail_single
            assign tail_empty = 1'b1;
        end else begin : g_tail_multi
            assign tail_empty = (vld_pipe[DEPTH-2:0] == '0);
        end
    endgenerate

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            S_IDLE: begin
                // abort is meaningless here; a simultaneous start still wins
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = (len == '0) ? S_DONE : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (abort)          state_nxt = S_IDLE;
                else if (last_read) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)           state_nxt = S_IDLE;
                else if (tail_empty) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Product extension and accumulate with the overflow rule of the chosen representation.
    always_comb begin
        if (IS_SIGNED) begin
            product_ext = ACC_W'($signed(mult_result));
        end else begin
            product_ext = ACC_W'(mult_result);
        end
        sum_wide = {1'b0, acc} + {1'b0, product_ext};
        acc_sum  = sum_wide[ACC_W-1:0];
        if (IS_SIGNED) begin
            add_ovf = (acc[ACC_W-1] == product_ext[ACC_W-1]) &&
                      (acc_sum[ACC_W-1] != acc[ACC_W-1]);
        end else begin
            add_ovf = sum_wide[ACC_W];
        end
        acc_nxt = product_vld ? acc_sum : acc;
        ovf_nxt = acc_ovf | (product_vld & add_ovf);
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state     <= S_IDLE;
            rd_addr   <= '0;
            remaining <= '0;
            vld_pipe  <= '0;
            acc       <= '0;
            acc_ovf   <= 1'b0;
            acc_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rd_addr   <= base_addr;
                remaining <= len;
                vld_pipe  <= '0;
                acc       <= '0;
                acc_ovf   <= 1'b0;
            end else begin
                if (rd_en) begin
                    rd_addr   <= rd_addr + ADDR_W'(1);
                    remaining <= remaining - LEN_W'(1);
                end
                // Flushing on abort guarantees in-flight products are never summed,
                // even if a new job starts immediately afterwards.
                if (abort && (state != S_IDLE)) begin
                    vld_pipe <= '0;
                end else begin
                    vld_pipe <= (vld_pipe << 1) | DEPTH'(rd_en);
                end
                acc     <= acc_nxt;
                acc_ovf <= ovf_nxt;
            end
            // Results become visible in the DONE cycle itself; the final product
            // is folded in on the same edge that enters DONE.
            if (state_nxt == S_DONE) begin
                acc_out  <= accept ? '0 : acc_nxt;
                overflow <= accept ? 1'b0 : ovf_nxt;
            end
        end
    end

endmodule

// File: tb/tb_mult_mac_sequencer.sv
// Directed bench for mult_mac_sequencer: one UNSIGNED and one SIGNED instance share
// stimulus, each with its own operand buffer read register and 2-stage multiplier model.
module tb_mult_mac_sequencer;

    localparam int WA = 8, WB = 8, WP = 16, AW = 24, ADW = 10, LW = 10;

    logic           clock = 1'b0;
    logic           aclr_n = 1'b1;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [ADW-1:0] base_addr = '0;
    logic [LW-1:0]  len = '0;
    logic [WA-1:0]  mem_a [0:1023];
    logic [WB-1:0]  mem_b [0:1023];

    logic           u_rd_en, s_rd_en;
    logic [ADW-1:0] u_rd_addr, s_rd_addr;
    logic [WA-1:0]  u_rd_a, s_rd_a, u_ma, s_ma;
    logic [WB-1:0]  u_rd_b, s_rd_b, u_mb, s_mb;
    logic           u_clken, s_clken;
    logic [WP-1:0]  u_p1, s_p1, u_res, s_res;
    logic           u_busy, s_busy, u_done, s_done, u_ovf, s_ovf;
    logic [AW-1:0]  u_acc, s_acc;

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    // Operand buffers (MEM_LAT = 1) and multipliers (PIPE = 2, clock-enabled).
    always @(posedge clock) begin
        if (u_rd_en) begin
            u_rd_a <= mem_a[u_rd_addr];
            u_rd_b <= mem_b[u_rd_addr];
        end
        if (s_rd_en) begin
            s_rd_a <= mem_a[s_rd_addr];
            s_rd_b <= mem_b[s_rd_addr];
        end
        if (u_clken) begin
            u_p1  <= 16'(u_ma) * 16'(u_mb);
            u_res <= u_p1;
        end
        if (s_clken) begin
            s_p1  <= 16'($signed(s_ma)) * 16'($signed(s_mb));
            s_res <= s_p1;
        end
    end

    mult_mac_sequencer #(
        .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_P(WP), .ACC_W(AW), .ADDR_W(ADW), .LEN_W(LW),
        .MEM_LAT(1), .PIPE(2), .REPRESENTATION("UNSIGNED")
    ) u_dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .rd_en(u_rd_en), .rd_addr(u_rd_addr),
        .rd_data_a(u_rd_a), .rd_data_b(u_rd_b), .mult_dataa(u_ma), .mult_datab(u_mb),
        .mult_clken(u_clken), .mult_result(u_res), .busy(u_busy), .done(u_done),
        .acc_out(u_acc), .overflow(u_ovf)
    );

    mult_mac_sequencer #(
        .WIDTH_A(WA), .WIDTH_B(WB), .WIDTH_P(WP), .ACC_W(AW), .ADDR_W(ADW), .LEN_W(LW),
        .MEM_LAT(1), .PIPE(2), .REPRESENTATION("SIGNED")
    ) s_dut (
        .clock(clock), .aclr_n(aclr_n), .start(start), .abort(abort),
        .base_addr(base_addr), .len(len), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_data_a(s_rd_a), .rd_data_b(s_rd_b), .mult_dataa(s_ma), .mult_datab(s_mb),
        .mult_clken(s_clken), .mult_result(s_res), .busy(s_busy), .done(s_done),
        .acc_out(s_acc), .overflow(s_ovf)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Starts a job from IDLE, returns the cycle of u_done (-1 if it never came),
    // then steps once more so the caller is back in IDLE.
    task automatic run_job(input logic [ADW-1:0] b, input logic [LW-1:0] l, output int done_cyc);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        step();
        start    = 1'b0;
        done_cyc = -1;
        for (int c = 1; c <= 600; c++) begin
            if (u_done) begin
                done_cyc = c;
                break;
            end
            step();
        end
        step();
    endtask

    task automatic fill(input logic [ADW-1:0] b, input int n, input logic [7:0] a, input logic [7:0] bb);
        logic [ADW-1:0] addr;
        for (int i = 0; i < n; i++) begin
            addr        = b + ADW'(i);
            mem_a[addr] = a;
            mem_b[addr] = bb;
        end
    endtask

    task automatic test_reset();
        aclr_n = 1'b1;
        #1;
        aclr_n = 1'b0;
        #1;
        vectors++;
        if ({u_busy, u_done, u_rd_en, u_clken, u_ovf} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_u_ctrl: got %b want 00000", {u_busy, u_done, u_rd_en, u_clken, u_ovf});
        end
        vectors++;
        if ({s_busy, s_done, s_rd_en, s_clken, s_ovf} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_s_ctrl: got %b want 00000", {s_busy, s_done, s_rd_en, s_clken, s_ovf});
        end
        vectors++;
        if ({u_rd_addr, u_acc, s_rd_addr, s_acc} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: got %h %h %h %h want 0", u_rd_addr, u_acc, s_rd_addr, s_acc);
        end
        step();
        aclr_n = 1'b1;
        step();
    endtask

    task automatic test_unsigned_len4();
        logic [ADW-1:0] a;
        logic [3:0]     exp_st;
        for (int i = 0; i < 4; i++) begin
            a        = 10'h3FE + ADW'(i);
            mem_a[a] = 8'(i + 1);
            mem_b[a] = 8'd2;
        end
        base_addr = 10'h3FE;
        len       = 10'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            exp_st = {c <= 7, c == 8, c <= 4, c <= 8};
            vectors++;
            if ({u_busy, u_done, u_rd_en, u_clken} !== exp_st) begin
                miscompares++;
                $display("FAIL len4_ctrl cycle %0d: got %b want %b", c, {u_busy, u_done, u_rd_en, u_clken}, exp_st);
            end
            if (c <= 4) begin
                a = 10'h3FE + ADW'(c - 1);
                vectors++;
                if (u_rd_addr !== a) begin
                    miscompares++;
                    $display("FAIL len4_addr cycle %0d: got %h want %h", c, u_rd_addr, a);
                end
            end
            if (c == 8) begin
                vectors++;
                if ({u_ovf, u_acc} !== {1'b0, 24'd20}) begin
                    miscompares++;
                    $display("FAIL len4_result: got ovf=%b acc=%0d want ovf=0 acc=20", u_ovf, u_acc);
                end
            end
            step();
        end
    endtask

    task automatic test_len_zero();
        base_addr = 10'h0;
        len       = 10'd0;
        start     = 1'b1;
        step();
        start = 1'b0;
        vectors++;
        if ({u_busy, u_done, u_rd_en} !== 3'b010) begin
            miscompares++;
            $display("FAIL len0_ctrl: got %b want 010", {u_busy, u_done, u_rd_en});
        end
        vectors++;
        if ({u_ovf, u_acc} !== 25'd0) begin
            miscompares++;
            $display("FAIL len0_result: got ovf=%b acc=%0d want 0 0", u_ovf, u_acc);
        end
        step();
        vectors++;
        if ({u_busy, u_done, u_rd_en} !== 3'b000) begin
            miscompares++;
            $display("FAIL len0_after: got %b want 000", {u_busy, u_done, u_rd_en});
        end
    endtask

    task automatic test_signed();
        fill(10'h010, 1, 8'hFD, 8'h05);
        base_addr = 10'h010;
        len       = 10'd1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            vectors++;
            if ({s_busy, s_done} !== {c <= 4, c == 5}) begin
                miscompares++;
                $display("FAIL signed_ctrl cycle %0d: got %b want %b", c, {s_busy, s_done}, {c <= 4, c == 5});
            end
            if (c == 5) begin
                vectors++;
                if ({s_ovf, s_acc} !== {1'b0, 24'hFFFFF1}) begin
                    miscompares++;
                    $display("FAIL signed_result: got ovf=%b acc=%h want ovf=0 acc=fffff1", s_ovf, s_acc);
                end
                vectors++;
                if ({u_ovf, u_acc} !== {1'b0, 24'd1265}) begin
                    miscompares++;
                    $display("FAIL zeroext_result: got ovf=%b acc=%0d want ovf=0 acc=1265", u_ovf, u_acc);
                end
            end
            step();
        end
    endtask

    task automatic test_overflow();
        int dc;
        fill(10'h100, 259, 8'hFF, 8'hFF);
        run_job(10'h100, 10'd259, dc);
        vectors++;
        if (dc !== 263) begin
            miscompares++;
            $display("FAIL ovf_done_cycle: got %0d want 263", dc);
        end
        vectors++;
        if ({u_ovf, u_acc} !== {1'b1, 24'd64259}) begin
            miscompares++;
            $display("FAIL ovf_result: got ovf=%b acc=%0d want ovf=1 acc=64259", u_ovf, u_acc);
        end
        fill(10'h300, 1, 8'h01, 8'h01);
        run_job(10'h300, 10'd1, dc);
        vectors++;
        if ({dc == 5, u_ovf, u_acc} !== {1'b1, 1'b0, 24'd1}) begin
            miscompares++;
            $display("FAIL ovf_clear: got done@%0d ovf=%b acc=%0d want done@5 ovf=0 acc=1", dc, u_ovf, u_acc);
        end
    endtask

    task automatic test_abort();
        fill(10'h020, 8, 8'd7, 8'd7);
        fill(10'h030, 2, 8'd3, 8'd3);
        base_addr = 10'h020;
        len       = 10'd8;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        vectors++;
        if ({u_busy, u_done, u_rd_en, u_clken} !== 4'b0000) begin
            miscompares++;
            $display("FAIL abort_ctrl: got %b want 0000", {u_busy, u_done, u_rd_en, u_clken});
        end
        vectors++;
        if ({u_ovf, u_acc} !== {1'b0, 24'd1}) begin
            miscompares++;
            $display("FAIL abort_hold: got ovf=%b acc=%0d want ovf=0 acc=1", u_ovf, u_acc);
        end
        // New job right away: anything left in flight must not leak into it.
        base_addr = 10'h030;
        len       = 10'd2;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            vectors++;
            if ({u_busy, u_done} !== {c <= 5, c == 6}) begin
                miscompares++;
                $display("FAIL abort_next_ctrl cycle %0d: got %b want %b", c, {u_busy, u_done}, {c <= 5, c == 6});
            end
            if (c == 6) begin
                vectors++;
                if ({u_ovf, u_acc} !== {1'b0, 24'd18}) begin
                    miscompares++;
                    $display("FAIL abort_next_result: got ovf=%b acc=%0d want ovf=0 acc=18", u_ovf, u_acc);
                end
            end
            step();
        end
    endtask

    task automatic test_start_hold();
        logic [2:0] exp_st;
        fill(10'h040, 2, 8'd2, 8'd3);
        base_addr = 10'h040;
        len       = 10'd2;
        start     = 1'b1;
        step();
        for (int c = 1; c <= 14; c++) begin
            exp_st = {(c <= 5) || (c >= 8 && c <= 12), (c == 6) || (c == 13),
                      (c == 1) || (c == 2) || (c == 8) || (c == 9)};
            vectors++;
            if ({u_busy, u_done, u_rd_en} !== exp_st) begin
                miscompares++;
                $display("FAIL hold_ctrl cycle %0d: got %b want %b", c, {u_busy, u_done, u_rd_en}, exp_st);
            end
            if (c == 8) begin
                vectors++;
                if (u_rd_addr !== 10'h040) begin
                    miscompares++;
                    $display("FAIL hold_restart_addr: got %h want 040", u_rd_addr);
                end
                start = 1'b0;
            end
            if (c == 13) begin
                vectors++;
                if (u_acc !== 24'd12) begin
                    miscompares++;
                    $display("FAIL hold_result: got %0d want 12", u_acc);
                end
            end
            step();
        end
    endtask

    task automatic test_reset_mid();
        int dc;
        fill(10'h050, 4, 8'd1, 8'd1);
        base_addr = 10'h050;
        len       = 10'd4;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        vectors++;
        if ({u_busy, u_rd_en} !== 2'b10) begin
            miscompares++;
            $display("FAIL mid_drain_state: got %b want 10", {u_busy, u_rd_en});
        end
        aclr_n = 1'b0;
        #1;
        vectors++;
        if ({u_busy, u_done, u_rd_en, u_clken, u_ovf, s_busy, s_clken} !== 7'b0) begin
            miscompares++;
            $display("FAIL mid_reset_ctrl: got %b want 0000000",
                     {u_busy, u_done, u_rd_en, u_clken, u_ovf, s_busy, s_clken});
        end
        vectors++;
        if ({u_rd_addr, u_acc} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_data: got addr=%h acc=%0d want 0 0", u_rd_addr, u_acc);
        end
        #2;
        aclr_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            step();
            vectors++;
            if ({u_busy, u_done} !== 2'b00) begin
                miscompares++;
                $display("FAIL mid_reset_quiet cycle %0d: got %b want 00", c, {u_busy, u_done});
            end
        end
        run_job(10'h050, 10'd1, dc);
        vectors++;
        if ({dc == 5, u_acc} !== {1'b1, 24'd1}) begin
            miscompares++;
            $display("FAIL mid_reset_recover: got done@%0d acc=%0d want done@5 acc=1", dc, u_acc);
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        test_reset();
        test_unsigned_len4();
        test_len_zero();
        test_signed();
        test_overflow();
        test_abort();
        test_start_hold();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
